// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment driver: shadow/active double buffering committed at frame wrap.
// Optional blink support is compiled in with the SEG7_BLINK_EN macro.
module seg7_mux_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [5*NUM_DIGITS-1:0] codes_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG7_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    pending,
   output logic                    frame_start
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   logic [PW-1:0]                  cnt;
   logic [IW-1:0]                  idx, idx_nxt;
   logic [NUM_DIGITS-1:0][4:0]     act_code, sh_code, code_nxt;
   logic [NUM_DIGITS-1:0]          act_blank, sh_blank, blank_nxt;
   logic [NUM_DIGITS-1:0]          an_nxt;
   logic [6:0]                     seg_nxt;
   logic                           tick, last, wrap, commit, dark;

`ifdef SEG7_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   logic [BW-1:0]                  fcnt;
   logic                           phase, phase_nxt; // phase=1 means blinking digits are dark
   logic [NUM_DIGITS-1:0]          act_blink, sh_blink, blink_nxt;
`endif

   function automatic logic [6:0] glyph(input logic [4:0] c);
      case (c)
         5'h00:   glyph = 7'b1000000;
         5'h01:   glyph = 7'b1111001;
         5'h02:   glyph = 7'b0100100;
         5'h03:   glyph = 7'b0110000;
         5'h04:   glyph = 7'b0011001;
         5'h05:   glyph = 7'b0010010;
         5'h06:   glyph = 7'b0000010;
         5'h07:   glyph = 7'b1111000;
         5'h08:   glyph = 7'b0000000;
         5'h09:   glyph = 7'b0010000;
         5'h0A:   glyph = 7'b1000110;
         5'h0B:   glyph = 7'b0100001;
         5'h0C:   glyph = 7'b0000110;
         5'h0D:   glyph = 7'b1000111;
         5'h0E:   glyph = 7'b1001000;
         5'h0F:   glyph = 7'b1000000;
         5'h10:   glyph = 7'b0001100;
         5'h11:   glyph = 7'b0010010;
         default: glyph = 7'b0111111;
      endcase
   endfunction

   // Outputs are registered from the post-edge view (next index, next active data)
   // so segments already match the new digit during the blank gap cycle.
   always_comb begin
      tick      = (cnt == PW'(REFRESH_DIV - 1));
      last      = (idx == IW'(NUM_DIGITS - 1));
      wrap      = tick && last;
      commit    = wrap && pending;
      idx_nxt   = idx;
      if (tick) idx_nxt = last ? '0 : idx + 1'b1;
      code_nxt  = commit ? sh_code  : act_code;
      blank_nxt = commit ? sh_blank : act_blank;
      dark      = blank_nxt[idx_nxt];
`ifdef SEG7_BLINK_EN
      blink_nxt = commit ? sh_blink : act_blink;
      phase_nxt = phase ^ (wrap && (fcnt == BW'(BLINK_FRAMES - 1)));
      dark      = dark | (blink_nxt[idx_nxt] & phase_nxt);
`endif
      seg_nxt   = dark ? 7'b1111111 : glyph(code_nxt[idx_nxt]);
      an_nxt    = '1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (idx_nxt == IW'(i)) an_nxt[i] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= '0;
         act_code    <= {NUM_DIGITS{5'h1F}};
         sh_code     <= {NUM_DIGITS{5'h1F}};
         act_blank   <= '0;
         sh_blank    <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
         an_n        <= '1;
         seg_n       <= 7'b1111111;
      end else begin
         cnt         <= tick ? '0 : cnt + 1'b1;
         idx         <= idx_nxt;
         act_code    <= code_nxt;
         act_blank   <= blank_nxt;
         if (load) begin
            sh_code  <= codes_in;
            sh_blank <= blank_in;
         end
         // a load on the wrap edge keeps pending set for the following frame
         pending     <= load | (pending & ~wrap);
         frame_start <= wrap;
         an_n        <= tick ? '1 : an_nxt;
         seg_n       <= seg_nxt;
      end
   end

`ifdef SEG7_BLINK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt      <= '0;
         phase     <= 1'b0;
         act_blink <= '0;
         sh_blink  <= '0;
      end else begin
         phase     <= phase_nxt;
         act_blink <= blink_nxt;
         if (load) sh_blink <= blink_in;
         if (wrap) fcnt <= (fcnt == BW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clocks per digit slot (>=4).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, frames per blink half-period (used only with SEG7_BLINK_EN).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 load  input  1  single-cycle strobe; captures codes_in and blank_in into shadow registers.
REQ-007 codes_in  input  5*NUM_DIGITS  glyph codes; digit k at bits [5k+4:5k].
REQ-008 blank_in  input  NUM_DIGITS  1 = digit k dark.
REQ-009 seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-010 an_n  output  NUM_DIGITS  active-low digit enables, registered, at most one low.
REQ-011 pending  output  1  shadow loaded but not yet committed.
REQ-012 frame_start  output  1  one-cycle pulse on commit/wrap to digit 0.

Function
REQ-013 Glyph map SHALL be: 0x00-0x09 digits 0-9 (0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000); 0x0A C 1000110; 0x0B D 0100001; 0x0C E 0000110; 0x0D L 1000111; 0x0E N 1001000; 0x0F O 1000000; 0x10 P 0001100; 0x11 S 0010010; all others dash 0111111.
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and assert internal tick on terminal count, then wrap to 0.
REQ-015 On tick, scan index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 Cycle after tick SHALL drive an_n all ones (anti-ghost gap), with seg_n already updated for the new index.
REQ-017 Second cycle after tick onward SHALL drive an_n with only bit [index] low until next tick.
REQ-018 seg_n SHALL be glyph of active code[index], or 1111111 when active blank[index]=1.
REQ-019 load=1 SHALL write shadow registers and set pending=1 next cycle; repeated loads before commit: last wins.
REQ-020 On tick wrapping index to 0, active registers SHALL take shadow values if pending=1, pending SHALL clear, frame_start SHALL pulse 1 cycle (pulse occurs every wrap regardless of pending).
REQ-021 load coincident with wrap tick: old shadow commits, new data captured into shadow, pending remains 1.
REQ-022 Display SHALL never show a mix of old and new data within one frame.

Reset
REQ-023 On rst: prescaler 0, index 0, active codes 0x1F (dash), active blank 0, shadow cleared to same, pending 0, frame_start 0, an_n all ones, seg_n 1111111.
REQ-024 rst mid-frame SHALL discard pending shadow; scan restarts at digit 0 after REFRESH_DIV clocks.

Configuration
REQ-025 Macro SEG7_BLINK_EN defined: adds input blink_in (NUM_DIGITS, shadowed/committed like blank_in); frame counter toggles blink phase every BLINK_FRAMES wraps; digit with blink=1 dark during off phase; phase resets to on.
REQ-026 SEG7_BLINK_EN undefined: no blink_in port, no frame counter; behaviour per REQ-013..022 only.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-027 Reset release, no load -> after each slot seg_n=0111111, an_n cycles 1110,1101,1011,0111 with 1111 gap cycle between.
REQ-028 load codes {0x03,0x02,0x01,0x00} mid-frame -> pending=1, digits unchanged until wrap; at wrap frame_start=1, pending=0, digit0 seg_n=1000000, digit3 seg_n=0110000.
REQ-029 Two loads before wrap (0x0A then 0x11 on all digits) -> all digits show 0010010 after commit.
REQ-030 blank_in=0100 loaded with codes 0x08 -> digit2 seg_n=1111111, others 0000000; load on wrap tick cycle -> pending stays 1, commits at following wrap.
REQ-031 rst asserted with pending=1 -> pending=0, an_n=1111, dashes displayed; SEG7_BLINK_EN with blink_in=0001 -> digit0 dark for 2 frames, lit for 2 frames.
